// File: rtl/sync_fifo_reader.sv
// sync_fifo_reader: drains a sync_fifo read port onto a valid/ready stream.
// A 2-entry output buffer absorbs the FIFO's one-cycle read latency, so a
// consumer that is always ready receives one word per clock.
// Optional feature: define SYNC_FIFO_RD_CNT_EN to add the rd_cnt port, which
// counts accepted words and wraps at 2^CNT_W.
module sync_fifo_reader #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_go,
  input  logic             fifo_empty,
  input  logic [DW-1:0]    fifo_data,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_data,
  output logic             busy
`ifdef SYNC_FIFO_RD_CNT_EN
  ,
  output logic [CNT_W-1:0] rd_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [1:0]    occ_reg, occ_next;
  logic          inflight_reg;
  logic [DW-1:0] head_reg, head_next;
  logic [DW-1:0] tail_reg, tail_next;
  logic          pop;
  logic [2:0]    pending;

  // The counter must hold at least one bit.
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  // Stream handshake, read request and activity flag. pending is the number
  // of words that will occupy the buffer once this cycle's pop and capture
  // settle; a new read is only safe while that leaves a free slot.
  always_comb begin
    m_valid    = (occ_reg != 2'd0);
    m_data     = head_reg;
    pop        = m_valid & m_ready;
    pending    = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    fifo_rd_en = (state_reg == RUN) & ~fifo_empty & (pending < 3'd2);
    busy       = (state_reg != IDLE) | (occ_reg != 2'd0) | inflight_reg;
  end

  // Next-state logic: RUN fetches, FLUSH only delivers what is already
  // buffered or in flight and returns to IDLE once both are empty.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (rd_go) state_next = RUN;
      RUN:     if (!rd_go) state_next = FLUSH;
      FLUSH: begin
        if (rd_go)
          state_next = RUN;
        else if ((occ_reg == 2'd0) && !inflight_reg)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Buffer update: capture appends at the tail, pop removes the head; when
  // both happen together the occupancy is unchanged and order is kept.
  always_comb begin
    occ_next  = occ_reg;
    head_next = head_reg;
    tail_next = tail_reg;
    case ({inflight_reg, pop})
      2'b01: begin
        if (occ_reg == 2'd2) head_next = tail_reg;
        occ_next = occ_reg - 2'd1;
      end
      2'b10: begin
        if (occ_reg == 2'd0) head_next = fifo_data;
        else                 tail_next = fifo_data;
        occ_next = occ_reg + 2'd1;
      end
      2'b11: begin
        if (occ_reg == 2'd1) begin
          head_next = fifo_data;
        end else begin
          head_next = tail_reg;
          tail_next = fifo_data;
        end
      end
      default: ;
    endcase
  end

  // State, buffer and in-flight registers; reset discards everything held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      occ_reg      <= 2'd0;
      inflight_reg <= 1'b0;
      head_reg     <= '0;
      tail_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      occ_reg      <= occ_next;
      inflight_reg <= fifo_rd_en;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
    end
  end

`ifdef SYNC_FIFO_RD_CNT_EN
  logic [CNT_W-1:0] rd_cnt_reg;

  // Accepted-word counter, free-running with natural wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rd_cnt_reg <= '0;
    else if (pop)
      rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
  end

  assign rd_cnt = rd_cnt_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Testbench for sync_fifo_reader: a cycle table from reset, directed corner
// sequences and a randomized run against a queue-based FIFO/stream model.
module tb_sync_fifo_reader;

  localparam int DW = 8;
`ifdef SYNC_FIFO_RD_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_go = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          busy;
`ifdef SYNC_FIFO_RD_CNT_EN
  logic [CW-1:0] rd_cnt;
`endif

  sync_fifo_reader #(.DW(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_go     (rd_go),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .busy      (busy)
`ifdef SYNC_FIFO_RD_CNT_EN
    ,
    .rd_cnt    (rd_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc = 0;
  int outstanding = 0;
  int rd_pulses = 0;
  int valid_cycles = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  int pop_cyc[$];
  int rd_cyc[$];
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  typedef struct {
    logic          go;
    logic          empty;
    logic [DW-1:0] data;
    logic          rdy;
    logic          e_rd;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic          e_busy;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rd_go = 1'b0;
    m_ready = 1'b0;
    fq.delete();
    exp_q.delete();
    outstanding = 0;
    acc = 0;
    prev_stall = 1'b0;
    fifo_empty = 1'b1;
    fifo_data = '0;
    @(negedge clk);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);
`ifdef SYNC_FIFO_RD_CNT_EN
    chk("rst_cnt", rd_cnt, 0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      fq.push_back(base + DW'(i));
      exp_q.push_back(base + DW'(i));
    end
    fifo_empty = (fq.size() == 0);
  endtask

  // One clock of stream traffic: drive, check at the falling edge, then let
  // the behavioural sync_fifo respond to the read and write of this cycle.
  task automatic tick(input logic go, input logic rdy, input logic wr, input logic [DW-1:0] wd);
    logic s_rd;
    logic s_pop;
    logic [DW-1:0] expw;
    rd_go = go;
    m_ready = rdy;
    @(negedge clk);
    s_rd = fifo_rd_en;
    s_pop = m_valid & m_ready;
    if (s_rd) begin
      chk("rd_guard", fifo_empty, 0);
      chk("bp_bound", 32'((outstanding + 1 - int'(s_pop)) <= 2), 1);
      rd_pulses++;
      rd_cyc.push_back(cyc);
    end
    if (outstanding > 0) chk("busy_held", busy, 1);
    if (prev_stall) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, prev_data);
    end
`ifdef SYNC_FIFO_RD_CNT_EN
    chk("rd_cnt", rd_cnt, CW'(acc));
`endif
    if (m_valid) valid_cycles++;
    if (s_pop) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_word: got %0h expected no word", m_data);
      end else begin
        expw = exp_q.pop_front();
        chk("m_data", m_data, expw);
        $display("cycle %0d pop data=%0h", cyc, m_data);
      end
      pop_cyc.push_back(cyc);
    end
    prev_stall = m_valid & ~m_ready;
    prev_data = m_data;
    @(posedge clk);
    #1;
    if (s_rd && fq.size() != 0) fifo_data = fq.pop_front();
    if (s_rd) outstanding++;
    if (s_pop) begin
      outstanding--;
      acc++;
    end
    if (wr) begin
      fq.push_back(wd);
      exp_q.push_back(wd);
    end
    fifo_empty = (fq.size() == 0);
    cyc++;
  endtask

  task automatic drain(input logic go, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick(go, 1'b1, 1'b0, '0);
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int e;
    #2;
    // Cycle table: inputs driven straight onto the FIFO port.
    vecs[0]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 8'h99, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 8'h44, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      rd_go = vecs[i].go;
      fifo_empty = vecs[i].empty;
      fifo_data = vecs[i].data;
      m_ready = vecs[i].rdy;
      @(negedge clk);
      $display("vec %0d rd_en=%0b valid=%0b data=%0h busy=%0b", i, fifo_rd_en, m_valid, m_data, busy);
      chk("vec_rd_en", fifo_rd_en, vecs[i].e_rd);
      chk("vec_valid", m_valid, vecs[i].e_valid);
      if (vecs[i].e_valid) chk("vec_data", m_data, vecs[i].e_data);
      chk("vec_busy", busy, vecs[i].e_busy);
      @(posedge clk);
      #1;
    end

    // Stream: 15 words, one per cycle starting 2 cycles after the first read.
    do_reset();
    preload(15, 8'h01);
    rd_cyc.delete();
    pop_cyc.delete();
    drain(1'b1, "stream");
    chk("stream_count", pop_cyc.size(), 15);
    if (rd_cyc.size() != 0 && pop_cyc.size() == 15)
      for (int i = 0; i < 15; i++) chk("stream_timing", pop_cyc[i], rd_cyc[0] + 2 + i);
`ifdef SYNC_FIFO_RD_CNT_EN
    chk("stream_cnt", rd_cnt, CW'(15));
`endif

    // Backpressure: two reads only, head held, then gap-free delivery.
    do_reset();
    preload(8, 8'h01);
    rd_pulses = 0;
    repeat (11) tick(1'b1, 1'b0, 1'b0, '0);
    chk("bp_reads", rd_pulses, 2);
    chk("bp_valid", m_valid, 1);
    chk("bp_head", m_data, 8'h01);
    pop_cyc.delete();
    drain(1'b1, "bp");
    chk("bp_count", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8)
      for (int i = 1; i < 8; i++) chk("bp_gapless", pop_cyc[i], pop_cyc[0] + i);

    // Empty guard, then a single word 2 cycles after empty falls.
    do_reset();
    rd_pulses = 0;
    valid_cycles = 0;
    repeat (20) tick(1'b1, 1'b1, 1'b0, '0);
    chk("guard_reads", rd_pulses, 0);
    chk("guard_valid", valid_cycles, 0);
    pop_cyc.delete();
    tick(1'b1, 1'b1, 1'b1, 8'hA5);
    e = cyc;
    drain(1'b1, "guard");
    chk("guard_latency", (pop_cyc.size() != 0) ? pop_cyc[0] : -1, e + 2);

    // Flush: rd_go drops while a read is issued with one word buffered.
    do_reset();
    preload(1, 8'h61);
    repeat (3) tick(1'b1, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b1, 8'h62);
    rd_pulses = 0;
    tick(1'b0, 1'b0, 1'b0, '0);
    chk("flush_rd_issued", rd_pulses, 1);
    fq.push_back(8'h63);
    fifo_empty = 1'b0;
    drain(1'b0, "flush");
    repeat (3) tick(1'b0, 1'b1, 1'b0, '0);
    chk("flush_no_reads", rd_pulses, 1);
    chk("flush_busy", busy, 0);
    chk("flush_fifo_left", fq.size(), 1);

    // Reset mid-stream with a full buffer, released between edges.
    do_reset();
    preload(4, 8'h40);
    repeat (6) tick(1'b1, 1'b0, 1'b0, '0);
    m_ready = 1'b1;
    #2;
    chk("pre_rst_valid", m_valid, 1);
    chk("pre_rst_rd_en", fifo_rd_en, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_valid", m_valid, 0);
    chk("async_rst_rd_en", fifo_rd_en, 0);
    chk("async_rst_busy", busy, 0);
    fq.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    outstanding = 0;
    acc = 0;
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    valid_cycles = 0;
    repeat (10) tick(1'b1, 1'b1, 1'b0, '0);
    chk("no_stale_words", valid_cycles, 0);

    // Randomized traffic against the queue model.
    do_reset();
    for (int i = 0; i < 500; i++)
      tick($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 1) == 1, DW'($urandom));
    drain(1'b1, "random");

`ifdef SYNC_FIFO_RD_CNT_EN
    // Counter wrap with a 4-bit counter: 17 transfers leave 1.
    do_reset();
    preload(17, 8'hC0);
    drain(1'b1, "wrap");
    chk("cnt_wrap", rd_cnt, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_reader.md
# sync_fifo_reader

Read-side controller for `sync_fifo`. It pops words from the FIFO's `rd_en`/`data_out`/`empty` port and presents them downstream on a valid/ready stream. It absorbs the FIFO's one-cycle read latency with a 2-entry output buffer, so a continuously ready consumer sees one word per clock. It sits between `sync_fifo` and any consumer that applies backpressure.

## Interface
- `DW`, 8, data width; matches `sync_fifo` data width.
- `CNT_W`, 16, width of the optional transfer counter.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rd_go`  in  1  drain enable; high = fetch from FIFO, low = stop fetching and flush what is held.
- `fifo_empty`  in  1  `empty` flag from `sync_fifo`.
- `fifo_data`  in  DW  `data_out` from `sync_fifo`; valid the cycle after `fifo_rd_en`.
- `fifo_rd_en`  out  1  `rd_en` to `sync_fifo`.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts when `m_valid & m_ready`.
- `m_data`  out  DW  output word.
- `busy`  out  1  state != IDLE, or buffer/in-flight non-empty.
- `rd_cnt`  out  CNT_W  accepted-word count (only with `SYNC_FIFO_RD_CNT_EN`).

## Operation
- Internal state:
  - FSM: IDLE, RUN, FLUSH.
  - 2-entry FIFO-ordered buffer with occupancy `occ` (0..2).
  - 1-bit `inflight` register = `fifo_rd_en` of the previous cycle.
- `pop = m_valid & m_ready`.
- `fifo_rd_en = (state==RUN) & ~fifo_empty & (occ + inflight - pop < 2)`. This path is combinational from registers, `fifo_empty` and `m_ready`.
- `fifo_rd_en` is never asserted while `fifo_empty` is high, so the FIFO never underflows.
- Capture: when `inflight` is 1, `fifo_data` is written into the buffer tail that cycle.
- Simultaneous capture and pop is legal: `occ` is unchanged, order is preserved, and no word is lost or duplicated.
- `m_valid = (occ != 0)`; `m_data` = buffer head.
- `m_data` holds stable while `m_valid & ~m_ready`.
- FSM transitions:
  - IDLE -> RUN when `rd_go` = 1.
  - RUN -> FLUSH when `rd_go` = 0.
  - FLUSH -> IDLE when `occ == 0` and `inflight == 0`.
  - FLUSH -> RUN when `rd_go` returns to 1.
- FLUSH issues no reads but still delivers buffered and in-flight words.
- A FIFO that becomes empty in RUN stalls fetching. State stays RUN.

## Timing
- Reset values: `fifo_rd_en` = 0, `m_valid` = 0, `m_data` = 0, `busy` = 0, `rd_cnt` = 0, state IDLE, `occ` = 0, `inflight` = 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). Buffered and in-flight words are discarded.
- Latency, with RUN active, `m_ready` high and the FIFO going non-empty at cycle N:
  - `fifo_rd_en` high in cycle N.
  - `fifo_data` valid in cycle N+1 and captured at the end of N+1.
  - `m_valid` high from N+2.
- Throughput: 1 word/cycle sustained while the FIFO is non-empty and `m_ready` = 1.
- Backpressure: with `m_ready` = 0, at most 2 words are fetched beyond the last accepted word, then `fifo_rd_en` stays low.
- `rd_go` deasserted at cycle N: `fifo_rd_en` is low from cycle N+1 (FSM registered). A read issued in cycle N still lands and is delivered.

## Configuration
- `SYNC_FIFO_RD_CNT_EN` defined:
  - `rd_cnt` port exists.
  - Increments by 1 on every `pop`.
  - Wraps from 2^CNT_W-1 to 0.
  - Cleared only by reset.
- Not defined: `rd_cnt` port and counter logic are absent. All other behaviour is identical.

## Test plan
- Stream: FIFO preloaded with 0x01..0x0F, `rd_go` = 1, `m_ready` = 1 -> `m_data` 0x01..0x0F on 15 consecutive cycles starting 2 cycles after the first `fifo_rd_en`; `rd_cnt` = 15.
- Backpressure: 8 words preloaded, `m_ready` = 0 for 10 cycles after `rd_go` -> exactly 2 `fifo_rd_en` pulses and `m_data` held at 0x01. After `m_ready` = 1, 0x01..0x08 arrive in order with no gaps or duplicates.
- Empty guard: FIFO empty, `rd_go` = 1 for 20 cycles -> `fifo_rd_en` never high and `m_valid` = 0. A single write of 0xA5 then appears on `m_data` 2 cycles after the FIFO's `empty` falls.
- Flush: drop `rd_go` in the same cycle `fifo_rd_en` is high, with 1 word buffered -> both words delivered, no further reads, state IDLE, `busy` = 0.
- Reset mid-stream: assert `rst` low between clock edges with `occ` = 2 -> `m_valid`, `fifo_rd_en` and `busy` go 0 immediately without a clock edge; after release, no stale words appear.
- Counter wrap (macro defined, CNT_W = 4): 17 transfers -> `rd_cnt` = 1.
